// File: rtl/floo_pkg.sv
// rtl/floo_pkg.sv - shared arbiter state type and index helper for floo router output stages
//
// Contents:
//   arb_state_e : output-link ownership state (Idle = free, Locked = held by a packet)
//   wrap_idx    : folds an index in [0, 2n) back into [0, n)

package floo_pkg;

  typedef enum logic {
    Idle   = 1'b0,
    Locked = 1'b1
  } arb_state_e;

  // Callers only ever add less than n to an index already below n, so a
  // single conditional subtract replaces a full modulo.
  function automatic int wrap_idx(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/floo_rr_pick.sv
// rtl/floo_rr_pick.sv - round-robin search for the first set request at or after a start index
//
// Parameters:
//   NumInputs : number of request lines
//   IdxWidth  : width of start/winner indices
// Ports:
//   req_i    in  [NumInputs]  request vector
//   start_i  in  [IdxWidth]   highest-priority index, must be < NumInputs
//   winner_o out [IdxWidth]   first requester found searching upward with wrap, 0 if none
//   any_o    out 1            at least one request set

module floo_rr_pick
  import floo_pkg::*;
#(
  parameter int unsigned NumInputs = 4,
  parameter int unsigned IdxWidth  = $clog2(NumInputs)
) (
  input  logic [NumInputs-1:0] req_i,
  input  logic [IdxWidth-1:0]  start_i,
  output logic [IdxWidth-1:0]  winner_o,
  output logic                 any_o
);

  logic [IdxWidth-1:0] idx;

  // Walk the offsets from farthest to nearest so the last hit written is the
  // closest one to start_i; this avoids a break/found flag in the loop.
  always_comb begin
    winner_o = '0;
    idx      = '0;
    for (int i = NumInputs - 1; i >= 0; i--) begin
      idx = IdxWidth'(wrap_idx(int'(start_i) + i, int'(NumInputs)));
      if (req_i[idx]) begin
        winner_o = idx;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/floo_wormhole_arbiter.sv
// rtl/floo_wormhole_arbiter.sv - wormhole round-robin arbiter granting one output link per packet
//
// Parameters:
//   NumInputs : requesters sharing the link (2..16)
//   flit_t    : flit type, passed through unmodified
//   IdxWidth  : width of grant index
// Ports:
//   clk_i        in  1               clock, rising edge
//   rst_ni       in  1               asynchronous active-low reset
//   valid_i      in  [NumInputs]     per-requester flit valid
//   ready_o      out [NumInputs]     per-requester flit accepted
//   data_i       in  [NumInputs]     per-requester flit
//   last_i       in  [NumInputs]     flit closes its packet
//   valid_o      out 1               output link valid
//   ready_i      in  1               output link ready
//   data_o       out flit_t          granted flit
//   last_o       out 1               last flag of granted flit
//   grant_idx_o  out [IdxWidth]      granted requester, 0 when none
//   locked_o     out 1               a packet currently holds the link

module floo_wormhole_arbiter
  import floo_pkg::*;
#(
  parameter int unsigned NumInputs = 4,
  parameter type         flit_t    = logic,
  parameter int unsigned IdxWidth  = $clog2(NumInputs)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumInputs-1:0]  valid_i,
  output logic [NumInputs-1:0]  ready_o,
  input  flit_t [NumInputs-1:0] data_i,
  input  logic [NumInputs-1:0]  last_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output flit_t                 data_o,
  output logic                  last_o,
  output logic [IdxWidth-1:0]   grant_idx_o,
  output logic                  locked_o
);

  arb_state_e          state_q;
  logic [IdxWidth-1:0] lock_q;
  logic [IdxWidth-1:0] prio_q;

  logic [IdxWidth-1:0] winner;
  logic                any_valid;
  logic [IdxWidth-1:0] sel;
  logic [IdxWidth-1:0] prio_next;
  logic                pkt_done;

  floo_rr_pick #(
    .NumInputs (NumInputs),
    .IdxWidth  (IdxWidth)
  ) i_rr_pick (
    .req_i    (valid_i),
    .start_i  (prio_q),
    .winner_o (winner),
    .any_o    (any_valid)
  );

  // While locked, only the owner is looked at; other valids are invisible.
  // valid_o depends on valid_i and state only, never on ready_i.
  assign sel         = (state_q == Locked) ? lock_q : winner;
  assign valid_o     = (state_q == Locked) ? valid_i[lock_q] : any_valid;
  assign data_o      = data_i[sel];
  assign last_o      = last_i[sel];
  assign grant_idx_o = sel;
  assign locked_o    = (state_q == Locked);

  always_comb begin
    ready_o = '0;
    if (state_q == Locked || any_valid) begin
      ready_o[sel] = ready_i;
    end
  end

  assign pkt_done  = valid_o && ready_i && last_o;
  assign prio_next = IdxWidth'(wrap_idx(int'(sel) + 1, int'(NumInputs)));

  // A stalled or multi-flit grant in Idle moves straight to Locked so the
  // winner cannot be displaced by a request appearing ahead of it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      lock_q  <= '0;
      prio_q  <= '0;
    end else begin
      case (state_q)
        Idle: begin
          if (any_valid) begin
            if (pkt_done) begin
              prio_q <= prio_next;
            end else begin
              state_q <= Locked;
              lock_q  <= winner;
            end
          end
        end
        Locked: begin
          if (pkt_done) begin
            state_q <= Idle;
            prio_q  <= prio_next;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_floo_wormhole_arbiter.sv
// tb/tb_floo_wormhole_arbiter.sv - directed vector table, corner sequences and random packet checks

module tb_floo_wormhole_arbiter;

  localparam int N = 4;

  logic              clk_i;
  logic              rst_ni;
  logic [N-1:0]      valid_i;
  logic [N-1:0]      ready_o;
  logic [N-1:0][7:0] data_i;
  logic [N-1:0]      last_i;
  logic              valid_o;
  logic              ready_i;
  logic [7:0]        data_o;
  logic              last_o;
  logic [1:0]        grant_idx_o;
  logic              locked_o;

  floo_wormhole_arbiter #(
    .NumInputs (N),
    .flit_t    (logic [7:0])
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .last_i      (last_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .last_o      (last_o),
    .grant_idx_o (grant_idx_o),
    .locked_o    (locked_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       ready;
    logic       e_valid;
    logic [3:0] e_ready;
    logic [1:0] e_idx;
    logic       e_locked;
    logic       e_last;
  } vec_t;

  vec_t tv[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] l, input logic r, input logic ev,
                     input logic [3:0] er, input logic [1:0] ei, input logic el, input logic elast);
    tv.push_back('{v, l, r, ev, er, ei, el, elast});
  endtask

  // random-phase bookkeeping
  logic [N-1:0] hs_prev;
  int           wait_cnt [N];
  int           max_wait, ilv_err, stall_err, onehot_err, data_err, pkts;
  logic         in_pkt, prev_stall;
  logic [1:0]   pkt_owner, prev_idx;
  logic [7:0]   prev_data;

  initial begin
    rst_ni  = 1'b0;
    valid_i = '0;
    last_i  = '0;
    ready_i = 1'b0;
    for (int k = 0; k < N; k++) data_i[k] = 8'hA0 + 8'(k);

    // reset state
    #1;
    check("rst_valid_o", 32'(valid_o), 0);
    check("rst_ready_o", 32'(ready_o), 0);
    check("rst_grant", 32'(grant_idx_o), 0);
    check("rst_locked", 32'(locked_o), 0);
    valid_i = 4'b1111;
    last_i  = 4'b1111;
    ready_i = 1'b1;
    #1;
    check("rst_idle_grant", 32'(grant_idx_o), 0);
    check("rst_idle_ready", 32'(ready_o), 32'h1);
    check("rst_idle_locked", 32'(locked_o), 0);
    @(negedge clk_i);
    valid_i = '0;
    rst_ni  = 1'b1;

    // fair rotation
    add(4'b1111, 4'b1111, 1, 1, 4'b0001, 0, 0, 1);
    add(4'b1111, 4'b1111, 1, 1, 4'b0010, 1, 0, 1);
    add(4'b1111, 4'b1111, 1, 1, 4'b0100, 2, 0, 1);
    add(4'b1111, 4'b1111, 1, 1, 4'b1000, 3, 0, 1);
    add(4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 0);
    // three-flit packet on input 2 while input 0 keeps requesting
    add(4'b0001, 4'b0001, 1, 1, 4'b0001, 0, 0, 1);
    add(4'b0101, 4'b0001, 1, 1, 4'b0100, 2, 0, 0);
    add(4'b0101, 4'b0001, 1, 1, 4'b0100, 2, 1, 0);
    add(4'b0101, 4'b0101, 1, 1, 4'b0100, 2, 1, 1);
    add(4'b1001, 4'b1001, 1, 1, 4'b1000, 3, 0, 1);
    add(4'b0001, 4'b0001, 1, 1, 4'b0001, 0, 0, 1);
    // single flit stalled five cycles, input 3 appears meanwhile
    add(4'b0010, 4'b0010, 0, 1, 4'b0000, 1, 0, 1);
    add(4'b1010, 4'b1010, 0, 1, 4'b0000, 1, 1, 1);
    add(4'b1010, 4'b1010, 0, 1, 4'b0000, 1, 1, 1);
    add(4'b1010, 4'b1010, 0, 1, 4'b0000, 1, 1, 1);
    add(4'b1010, 4'b1010, 0, 1, 4'b0000, 1, 1, 1);
    add(4'b1010, 4'b1010, 1, 1, 4'b0010, 1, 1, 1);
    add(4'b1000, 4'b1000, 1, 1, 4'b1000, 3, 0, 1);
    // two-flit packet on input 3 with a two-cycle bubble
    add(4'b0100, 4'b0100, 1, 1, 4'b0100, 2, 0, 1);
    add(4'b1001, 4'b0001, 1, 1, 4'b1000, 3, 0, 0);
    add(4'b0001, 4'b0001, 1, 0, 4'b1000, 3, 1, 0);
    add(4'b0001, 4'b0001, 1, 0, 4'b1000, 3, 1, 0);
    add(4'b1001, 4'b1001, 1, 1, 4'b1000, 3, 1, 1);
    add(4'b0001, 4'b0001, 1, 1, 4'b0001, 0, 0, 1);

    foreach (tv[i]) begin
      @(negedge clk_i);
      valid_i = tv[i].valid;
      last_i  = tv[i].last;
      ready_i = tv[i].ready;
      #1;
      check($sformatf("v%0d_valid", i), 32'(valid_o), 32'(tv[i].e_valid));
      check($sformatf("v%0d_ready", i), 32'(ready_o), 32'(tv[i].e_ready));
      check($sformatf("v%0d_grant", i), 32'(grant_idx_o), 32'(tv[i].e_idx));
      check($sformatf("v%0d_locked", i), 32'(locked_o), 32'(tv[i].e_locked));
      if (tv[i].e_valid) begin
        check($sformatf("v%0d_last", i), 32'(last_o), 32'(tv[i].e_last));
        check($sformatf("v%0d_data", i), 32'(data_o), 32'(8'hA0 + 8'(tv[i].e_idx)));
      end
    end

    // reset in the middle of a packet held by input 2
    @(negedge clk_i);
    valid_i = 4'b0100;
    last_i  = 4'b0000;
    ready_i = 1'b1;
    #1;
    check("mid_rst_grant_pre", 32'(grant_idx_o), 2);
    @(negedge clk_i);
    #1;
    check("mid_rst_locked_pre", 32'(locked_o), 1);
    #2;
    valid_i = 4'b0101;
    rst_ni  = 1'b0;
    #1;
    check("mid_rst_locked", 32'(locked_o), 0);
    check("mid_rst_grant", 32'(grant_idx_o), 0);
    check("mid_rst_ready", 32'(ready_o), 32'h1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("post_rst_grant", 32'(grant_idx_o), 0);
    check("post_rst_locked", 32'(locked_o), 0);

    // valid_o must not react to ready_i
    @(negedge clk_i);
    rst_ni  = 1'b0;
    valid_i = '0;
    @(negedge clk_i);
    rst_ni  = 1'b1;
    valid_i = 4'b0010;
    last_i  = 4'b0010;
    ready_i = 1'b0;
    #1;
    check("rdy_path_valid_lo", 32'(valid_o), 1);
    check("rdy_path_ready_lo", 32'(ready_o), 0);
    ready_i = 1'b1;
    #1;
    check("rdy_path_valid_hi", 32'(valid_o), 1);
    check("rdy_path_ready_hi", 32'(ready_o), 32'h2);

    // random traffic with protocol-compliant requesters
    @(negedge clk_i);
    rst_ni  = 1'b0;
    valid_i = '0;
    @(negedge clk_i);
    rst_ni     = 1'b1;
    hs_prev    = '0;
    in_pkt     = 1'b0;
    pkt_owner  = '0;
    prev_stall = 1'b0;
    prev_idx   = '0;
    prev_data  = '0;
    max_wait = 0; ilv_err = 0; stall_err = 0; onehot_err = 0; data_err = 0; pkts = 0;
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc != 0) @(negedge clk_i);
      for (int k = 0; k < N; k++) begin
        if (hs_prev[k] || (!valid_i[k] && $urandom_range(0, 3) == 0)) begin
          valid_i[k] = hs_prev[k] ? 1'($urandom_range(0, 1)) : 1'b1;
          data_i[k]  = 8'($urandom);
          last_i[k]  = ($urandom_range(0, 2) == 0);
        end
      end
      ready_i = ($urandom_range(0, 3) != 0);
      #1;
      if ($countones(ready_o) > 1) onehot_err++;
      if (prev_stall && (!valid_o || grant_idx_o != prev_idx || data_o != prev_data)) stall_err++;
      prev_stall = valid_o && !ready_i;
      prev_idx   = grant_idx_o;
      prev_data  = data_o;
      for (int k = 0; k < N; k++) hs_prev[k] = valid_i[k] && ready_o[k];
      if (valid_o && ready_i) begin
        if (in_pkt && grant_idx_o != pkt_owner) ilv_err++;
        if (data_o != data_i[grant_idx_o]) data_err++;
        in_pkt    = !last_o;
        pkt_owner = grant_idx_o;
        if (last_o) begin
          pkts++;
          for (int k = 0; k < N; k++) begin
            if (k != int'(grant_idx_o) && valid_i[k]) begin
              wait_cnt[k]++;
              if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
            end
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (!valid_i[k] || hs_prev[k]) wait_cnt[k] = 0;
      end
    end

    check("rand_interleave", 32'(ilv_err), 0);
    check("rand_stall_stable", 32'(stall_err), 0);
    check("rand_ready_onehot", 32'(onehot_err), 0);
    check("rand_data", 32'(data_err), 0);
    check("rand_fairness", 32'(max_wait <= N - 1), 1);
    check("rand_progress", 32'(pkts > 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/floo_wormhole_arbiter.md
FLOO_WORMHOLE_ARBITER -- requirements
Module: floo_wormhole_arbiter

Interface
REQ-001 SHALL have parameter NumInputs, default 4, number of requesters sharing one output link; legal range 2..16.
REQ-002 SHALL have parameter flit_t, default logic, flit type carried unmodified.
REQ-003 SHALL have parameter IdxWidth, default $clog2(NumInputs), width of the grant index.
REQ-004 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port valid_i  input  NumInputs  per-requester flit valid.
REQ-007 SHALL have port ready_o  output  NumInputs  per-requester flit accepted.
REQ-008 SHALL have port data_i  input  NumInputs x flit_t  per-requester flit.
REQ-009 SHALL have port last_i  input  NumInputs  flit is the final flit of its packet.
REQ-010 SHALL have port valid_o  output  1  output link valid.
REQ-011 SHALL have port ready_i  input  1  output link ready.
REQ-012 SHALL have port data_o  output  flit_t  granted flit.
REQ-013 SHALL have port last_o  output  1  last flag of the granted flit.
REQ-014 SHALL have port grant_idx_o  output  IdxWidth  index of the currently granted requester, 0 when none.
REQ-015 SHALL have port locked_o  output  1  high while a packet holds the link.

Function
REQ-016 SHALL implement two states: IDLE (no owner) and LOCKED (owner register lock_q holds link).
REQ-017 In IDLE, winner SHALL be the first requester with valid_i set, searching upward from prio_q with wrap-around past NumInputs-1 to 0.
REQ-018 In IDLE with any valid_i, valid_o SHALL be 1 in the same cycle, data_o/last_o/grant_idx_o taken from the winner, ready_o[winner]=ready_i, all other ready_o=0.
REQ-019 In IDLE with no valid_i, valid_o=0, ready_o=0, grant_idx_o=0, locked_o=0.
REQ-020 IDLE->IDLE SHALL occur on handshake (valid_o&&ready_i) with last_o=1; prio_q<=winner+1 mod NumInputs.
REQ-021 IDLE->LOCKED SHALL occur when valid_o=1 and either ready_i=0 or last_o=0; lock_q<=winner; prio_q unchanged. This keeps the output stable while stalled.
REQ-022 In LOCKED, only lock_q SHALL be connected: valid_o=valid_i[lock_q], ready_o[lock_q]=ready_i, others 0, grant_idx_o=lock_q, locked_o=1.
REQ-023 LOCKED->IDLE SHALL occur on handshake with last_o=1; prio_q<=lock_q+1 mod NumInputs. Any other cycle stays LOCKED, including cycles where valid_i[lock_q]=0 (bubble in packet).
REQ-024 Combinational latency SHALL be zero: no flit register in the datapath.
REQ-025 Once valid_o rises, data_o and grant_idx_o SHALL stay constant until handshake, provided the owner holds its flit stable.
REQ-026 Single-flit packets, valid_i=1 and last_i=1, SHALL complete in one cycle with ready_i=1, with no LOCKED cycle.
REQ-027 Valid inputs of non-owners SHALL be ignored: no ready, no state change.
REQ-028 There SHALL be no combinational path from ready_i to valid_o.

Reset
REQ-029 Assertion of rst_ni=0 SHALL force state=IDLE, lock_q=0, prio_q=0 asynchronously; a packet in progress is abandoned.
REQ-030 During reset, outputs SHALL follow IDLE equations with prio_q=0.

Structure
REQ-031 The state enum (Idle, Locked) SHALL be placed in floo_pkg for reuse by router output stages.
REQ-032 The round-robin search SHALL be one sub-module, floo_rr_pick: inputs are request vector and start index; outputs are winner index and any.
REQ-033 The block SHALL be usable as the per-output arbiter of floo_router for req, rsp and wide links without modification.

Verification
REQ-034 Reset, then valid_i=4'b1111, all last=1, ready_i=1 for 4 cycles -> grant_idx_o sequence 0,1,2,3; locked_o=0 throughout.
REQ-035 Input 2 sends 3-flit packet (last on third); input 0 valid throughout -> grant_idx_o=2 for 3 handshakes, then 0; prio_q=3 after the packet.
REQ-036 Input 1 valid with last=1, ready_i=0 for 5 cycles, input 3 raised at cycle 2 -> grant_idx_o=1 and data_o stable all 5 cycles, locked_o=1; handshake on cycle 6 with ready_i=1.
REQ-037 Input 3 packet of 2 flits with a 2-cycle valid_i bubble between flits, input 0 valid -> ready_o[0]=0 during bubble; link returns to IDLE only after second flit.
REQ-038 rst_ni pulsed low mid-packet (lock_q=2) -> next cycle IDLE, prio_q=0, input 0 granted if valid.
REQ-039 Random valid/last/ready, 10k cycles, NumInputs=5 -> no interleaving of packets on output; every requester served within 4 packets of others (fairness scoreboard).
